mux4_arbiter: RTL and testbench

MUX4_ARBITER -- requirements
Module: mux4_arbiter

---
 rtl/mux4_arbiter.sv | 118 +++++++++++
 tb/tb_mux4_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mux4_arbiter.sv
// mux4_arbiter
//   Four-requester arbiter feeding a single registered output slot.
//   Each requester presents 4-bit data with a valid bit. When the output
//   register is free, one requester is granted via in_ready. Its data
//   appears on y on the next cycle.
//
//   Arbitration policy is selected at build time:
//     MUX4_ARBITER_ROUND_ROBIN_EN defined   -> round-robin from pointer ptr
//     MUX4_ARBITER_ROUND_ROBIN_EN undefined -> fixed priority (0 highest);
//                                              ptr is tied to 0
//
// Ports
//   clk       in   1  clock, rising edge
//   rst       in   1  synchronous active-high reset
//   in_valid  in   4  per-requester valid
//   d0..d3    in   4  per-requester data
//   in_ready  out  4  one-hot grant (data accepted this cycle)
//   y         out  4  registered selected data
//   y_valid   out  1  y holds an undelivered item
//   y_ready   in   1  consumer accepts y
//   y_src     out  2  requester index of the data in y
//   xfer_cnt  out  8  wrapping count of accepted items
module mux4_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_valid,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic [3:0] in_ready,
  output logic [3:0] y,
  output logic       y_valid,
  input  logic       y_ready,
  output logic [1:0] y_src,
  output logic [7:0] xfer_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [1:0]      ptr;
  logic [1:0]      win;
  logic [1:0]      idx;
  logic            found;
  logic            out_free;
  logic            accept;
  logic [3:0][3:0] din;

  assign din      = {d3, d2, d1, d0};
  assign y_valid  = (state_q == FULL);
  // The slot can take a new item when empty, or when its item drains this cycle.
  assign out_free = !y_valid || y_ready;

  // Search order ptr, ptr+1, ptr+2, ptr+3 (mod 4); 2-bit add wraps naturally.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Grant is gated by rst so nothing is reported accepted while in reset.
  assign accept   = found && out_free && !rst;
  assign in_ready = accept ? (4'b0001 << win) : 4'b0000;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Next state: accept always fills; drain without accept empties; stall holds.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept)       state_d = FULL;
        else if (y_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Output data path and transfer counter. y/y_src hold on drain-only cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      y        <= 4'b0000;
      y_src    <= 2'b00;
      xfer_cnt <= 8'd0;
    end else if (accept) begin
      y        <= din[win];
      y_src    <= win;
      xfer_cnt <= xfer_cnt + 8'd1;
    end
  end

`ifdef MUX4_ARBITER_ROUND_ROBIN_EN
  // Winner drops to lowest priority: pointer moves just past it.
  logic [1:0] ptr_q;
  always_ff @(posedge clk) begin
    if (rst)         ptr_q <= 2'b00;
    else if (accept) ptr_q <= win + 2'd1;
  end
  assign ptr = ptr_q;
`else
  // Fixed priority: search always starts at requester 0.
  assign ptr = 2'b00;
`endif

endmodule

// File: tb/tb_mux4_arbiter.sv
// Directed testbench for mux4_arbiter. Covers reset, throughput with all
// requesters active, alternating requesters, stall/hold, drain, counter
// wrap and reset while full. Expected values depend on whether
// MUX4_ARBITER_ROUND_ROBIN_EN is defined.
module tb_mux4_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_valid;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] in_ready;
  logic [3:0] y;
  logic       y_valid;
  logic       y_ready;
  logic [1:0] y_src;
  logic [7:0] xfer_cnt;

  int n_chk = 0;
  int n_err = 0;

`ifdef MUX4_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  mux4_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .d0       (d0),
    .d1       (d1),
    .d2       (d2),
    .d3       (d3),
    .in_ready (in_ready),
    .y        (y),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .y_src    (y_src),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] w;
    logic [3:0] dv [4];

    rst = 1'b1; in_valid = 4'b0000; y_ready = 1'b0;
    d0 = 4'h0; d1 = 4'h0; d2 = 4'h0; d3 = 4'h0;
    tick(); tick();

    // Reset state
    check("rst_y_valid", 32'(y_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_y_src", 32'(y_src), 32'd0);
    check("rst_xfer", 32'(xfer_cnt), 32'd0);
    in_valid = 4'b1111;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);

    // Idle cycle: no requests, no state change
    rst = 1'b0; in_valid = 4'b0000; y_ready = 1'b1;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("idle_y_valid", 32'(y_valid), 32'd0);
    check("idle_xfer", 32'(xfer_cnt), 32'd0);

    // All four requesting, data 1..4, consumer always ready
    in_valid = 4'b1111; d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
    dv[0] = 4'd1; dv[1] = 4'd2; dv[2] = 4'd3; dv[3] = 4'd4;
    for (int k = 0; k < 5; k++) begin
      w = RR ? 2'(k) : 2'd0;
      #1;
      check("all_in_ready", 32'(in_ready), 32'(4'b0001 << w));
      tick();
      check("all_y", 32'(y), 32'(dv[w]));
      check("all_y_src", 32'(y_src), 32'(w));
      check("all_y_valid", 32'(y_valid), 32'd1);
      check("all_xfer", 32'(xfer_cnt), 32'(k + 1));
    end

    // Requesters 0 and 2 only, A and C
    do_reset();
    in_valid = 4'b0101; d0 = 4'hA; d2 = 4'hC; y_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w = (RR && (k % 2 == 1)) ? 2'd2 : 2'd0;
      #1;
      check("alt_in_ready", 32'(in_ready), 32'(4'b0001 << w));
      tick();
      check("alt_y", 32'(y), (w == 2'd2) ? 32'hC : 32'hA);
      check("alt_y_src", 32'(y_src), 32'(w));
      check("alt_xfer", 32'(xfer_cnt), 32'(k + 1));
    end

    // Stall: load 5, then hold for 3 cycles with all requesting
    do_reset();
    in_valid = 4'b0001; d0 = 4'd5; y_ready = 1'b1;
    tick();
    check("stall_load_y", 32'(y), 32'd5);
    in_valid = 4'b1111; d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4; y_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
      check("stall_y", 32'(y), 32'd5);
      check("stall_y_valid", 32'(y_valid), 32'd1);
      check("stall_y_src", 32'(y_src), 32'd0);
    end
    y_ready = 1'b1;
    #1;
    check("unstall_in_ready", 32'(in_ready), RR ? 32'b0010 : 32'b0001);
    tick();
    check("unstall_y", 32'(y), RR ? 32'd2 : 32'd1);
    check("unstall_y_src", 32'(y_src), RR ? 32'd1 : 32'd0);
    check("unstall_xfer", 32'(xfer_cnt), 32'd2);

    // Drain with no new request: empties, y and y_src hold
    in_valid = 4'b0000;
    tick();
    check("drain_y_valid", 32'(y_valid), 32'd0);
    check("drain_y", 32'(y), RR ? 32'd2 : 32'd1);
    check("drain_y_src", 32'(y_src), RR ? 32'd1 : 32'd0);
    check("drain_xfer", 32'(xfer_cnt), 32'd2);

    // Counter wrap: 260 transfers -> 4
    do_reset();
    in_valid = 4'b0001; d0 = 4'd7; y_ready = 1'b1;
    repeat (260) tick();
    check("wrap_xfer", 32'(xfer_cnt), 32'd4);
    check("wrap_y_valid", 32'(y_valid), 32'd1);

    // Reset while full with requester 1 pending
    rst = 1'b1; in_valid = 4'b0010; y_ready = 1'b0; d1 = 4'd9;
    #1;
    check("rstfull_in_ready_pre", 32'(in_ready), 32'd0);
    tick();
    check("rstfull_y_valid", 32'(y_valid), 32'd0);
    check("rstfull_y", 32'(y), 32'd0);
    check("rstfull_xfer", 32'(xfer_cnt), 32'd0);
    check("rstfull_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'b0010);
    tick();
    check("post_rst_y", 32'(y), 32'd9);
    check("post_rst_y_src", 32'(y_src), 32'd1);
    check("post_rst_y_valid", 32'(y_valid), 32'd1);
    check("post_rst_xfer", 32'(xfer_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
